fmap_stream_serializer_8ch: RTL and testbench

//   Downstream stage of block1_conv1_to_maxpool. Captures the 8 parallel pooled channel words

---
 rtl/fmap_stream_serializer_8ch.sv | 131 +++++++++++++
 tb/tb_fmap_stream_serializer_8ch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_serializer_8ch.sv
// Buffers 8-channel pooled pixel vectors in a FIFO and replays each one as eight
// sequential channel words on a valid/ready stream, with frame-end marking.
module fmap_stream_serializer_8ch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 112,
  parameter int unsigned HEIGHT     = 112,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic [DATA_WIDTH-1:0] data_in_4,
  input  logic [DATA_WIDTH-1:0] data_in_5,
  input  logic [DATA_WIDTH-1:0] data_in_6,
  input  logic [DATA_WIDTH-1:0] data_in_7,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            ch_idx,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
  localparam int unsigned CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W     = AW + 1;

  typedef logic [7:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  vec_t             mem [FIFO_DEPTH];
  vec_t             vec_in;
  vec_t             head;
  vec_t             shadow;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] pix_cnt;
  logic             empty;
  logic             full;
  logic             ch7_hs;
  logic             pop;
  logic             push;
  logic             frame_end;

  assign vec_in = {data_in_7, data_in_6, data_in_5, data_in_4,
                   data_in_3, data_in_2, data_in_1, data_in_0};
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot on the same edge, so a push into a full FIFO still lands then.
  assign ch7_hs    = (state == SEND) && ready_in && (ch_idx == 3'd7);
  assign pop       = !empty && ((state == IDLE) || ch7_hs);
  assign push      = valid_in && (!full || pop);
  assign frame_end = (pix_cnt == CNT_W'(FRAME_PIX - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= vec_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (valid_in && !push) overflow <= 1'b1;
    end
  end

  // Serializer FSM: shadow holds the vector being replayed, channel by channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      pix_cnt   <= '0;
      data_out  <= '0;
      ch_idx    <= 3'd0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shadow    <= head;
            data_out  <= head[0];
            ch_idx    <= 3'd0;
            valid_out <= 1'b1;
            last_out  <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (ready_in) begin
            if (ch_idx != 3'd7) begin
              ch_idx   <= ch_idx + 3'd1;
              data_out <= shadow[ch_idx + 3'd1];
              last_out <= (ch_idx == 3'd6) && frame_end;
            end else begin
              pix_cnt <= frame_end ? '0 : pix_cnt + CNT_W'(1);
              done    <= frame_end;
              if (pop) begin
                shadow   <= head;
                data_out <= head[0];
                ch_idx   <= 3'd0;
                last_out <= 1'b0;
              end else begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_stream_serializer_8ch.sv
// Self-checking bench for fmap_stream_serializer_8ch on a 2x2 frame: scoreboard of
// expected words plus directed checks for latency, stalls, overflow, frame end and reset.
module tb_fmap_stream_serializer_8ch;

  localparam int unsigned DW    = 32;
  localparam int unsigned W     = 2;
  localparam int unsigned H     = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FRAME = W * H;

  typedef logic [7:0][DW-1:0] vec_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    ch;
    logic          last;
  } exp_t;
  typedef struct {
    vec_t vec;
    bit   drop;
    logic exp_ovf;
  } tv_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  vec_t          din;
  logic [DW-1:0] data_out;
  logic [2:0]    ch_idx;
  logic          valid_out;
  logic          ready_in;
  logic          last_out;
  logic          overflow;
  logic          done;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   mpix = 0;
  int   done_cnt = 0;
  logic pend_done = 1'b0;

  fmap_stream_serializer_8ch #(
    .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
    .data_out(data_out), .ch_idx(ch_idx), .valid_out(valid_out), .ready_in(ready_in),
    .last_out(last_out), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input int unsigned base);
    vec_t v;
    for (int c = 0; c < 8; c++) v[c] = DW'(base + 32'(c));
    return v;
  endfunction

  // Drive one vector for one edge; accepted vectors are queued as 8 expected words.
  task automatic push_vec(input vec_t v, input bit drop);
    valid_in = 1'b1;
    din      = v;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (!drop) begin
      for (int c = 0; c < 8; c++)
        q.push_back({v[c], 3'(c), (c == 7) && (mpix == int'(FRAME) - 1)});
      mpix = (mpix + 1) % int'(FRAME);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    mpix = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d words still expected, expected 0", name, q.size());
    end
    @(posedge clk);
    #1;
    check({name, "_idle_valid"}, 64'(valid_out), 64'd0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares every handshaken word and the done pulse.
  always @(negedge clk) begin
    if (reset) begin
      pend_done = 1'b0;
    end else begin
      check("done", 64'(done), 64'(pend_done));
      if (done) done_cnt++;
      pend_done = 1'b0;
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got %0h ch %0d, expected no word", data_out, ch_idx);
        end else begin
          e = q.pop_front();
          check("data_out", 64'(data_out), 64'(e.data));
          check("ch_idx", 64'(ch_idx), 64'(e.ch));
          check("last_out", 64'(last_out), 64'(e.last));
          pend_done = e.last;
        end
      end
    end
  end

  initial begin
    vec_t v3;
    vec_t v6a;
    vec_t v6b;
    vec_t tv2[4];
    tv_t  tv4[18];
    int   cnt;
    int   k;
    bit   found;
    int   done_base;

    for (int i = 0; i < 4; i++) tv2[i] = mkvec(32'h1000_0000 + 32'(i) * 32'h100);
    for (int i = 0; i < 18; i++) begin
      tv4[i].vec     = mkvec(32'h2000_0000 + 32'(i) * 32'h10);
      tv4[i].drop    = (i == 17);
      tv4[i].exp_ovf = (i == 17);
    end

    valid_in = 1'b0;
    din      = '0;
    ready_in = 1'b1;
    do_reset();
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_ch_idx", 64'(ch_idx), 64'd0);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_last_out", 64'(last_out), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Single vector: first word one cycle after the push edge.
    @(posedge clk);
    #1;
    push_vec(mkvec(32'h3F80_0000), 1'b0);
    check("t1_valid_at_push", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1;
    check("t1_valid_next", 64'(valid_out), 64'd1);
    check("t1_first_word", 64'(data_out), 64'h3F80_0000);
    check("t1_first_ch", 64'(ch_idx), 64'd0);
    drain("t1");

    // Four back-to-back vectors: 32 words with no gaps.
    fork
      begin
        for (int i = 0; i < 4; i++) push_vec(tv2[i], 1'b0);
      end
      begin
        cnt = 0;
        k = 0;
        @(negedge clk);
        while (!valid_out && k < 50) begin
          @(negedge clk);
          k++;
        end
        while (valid_out && cnt < 200) begin
          cnt++;
          @(negedge clk);
        end
        check("t2_contiguous_words", 64'(cnt), 64'd32);
      end
    join
    drain("t2");

    // Stall ch1 for two cycles.
    v3 = mkvec(32'h4000_0000);
    push_vec(v3, 1'b0);
    k = 0;
    @(negedge clk);
    while (!valid_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    check("t3_stall1_data", 64'(data_out), 64'(v3[1]));
    check("t3_stall1_ch", 64'(ch_idx), 64'd1);
    @(posedge clk);
    #1;
    check("t3_stall2_data", 64'(data_out), 64'(v3[1]));
    check("t3_stall2_ch", 64'(ch_idx), 64'd1);
    @(posedge clk);
    #1;
    check("t3_stall3_data", 64'(data_out), 64'(v3[1]));
    check("t3_stall3_ch", 64'(ch_idx), 64'd1);
    ready_in = 1'b1;
    drain("t3");

    // Overflow: the first vector moves to the shadow, 16 fill the FIFO, the 18th drops.
    ready_in = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push_vec(tv4[i].vec, tv4[i].drop);
      check($sformatf("t4_overflow_push%0d", i), 64'(overflow), 64'(tv4[i].exp_ovf));
    end
    repeat (3) @(posedge clk);
    #1;
    check("t4_overflow_sticky", 64'(overflow), 64'd1);
    ready_in = 1'b1;
    drain("t4");

    // Two full 2x2 frames: last_out on word 32 of each, done one cycle later.
    do_reset();
    check("t5_overflow_cleared", 64'(overflow), 64'd0);
    done_base = done_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_vec(mkvec(32'h5000_0000 + 32'(i) * 32'h20), 1'b0);
    drain("t5");
    check("t5_done_pulses", 64'(done_cnt - done_base), 64'd2);

    // Reset while presenting ch3 of pixel 1, then a fresh frame from counter 0.
    v6a = mkvec(32'h6000_0000);
    v6b = mkvec(32'h6100_0000);
    push_vec(v6a, 1'b0);
    push_vec(v6b, 1'b0);
    found = 1'b0;
    for (int j = 0; j < 60 && !found; j++) begin
      @(negedge clk);
      if (valid_out && ch_idx == 3'd3 && data_out == v6b[3]) found = 1'b1;
    end
    check("t6_reached_px1_ch3", 64'(found), 64'd1);
    #1;
    reset = 1'b1;
    q.delete();
    mpix = 0;
    #1;
    check("t6_valid_in_reset", 64'(valid_out), 64'd0);
    check("t6_data_in_reset", 64'(data_out), 64'd0);
    check("t6_ch_in_reset", 64'(ch_idx), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    done_base = done_cnt;
    for (int i = 0; i < 4; i++) push_vec(mkvec(32'h7000_0000 + 32'(i) * 32'h40), 1'b0);
    drain("t6");
    check("t6_done_pulses", 64'(done_cnt - done_base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
